// File: rtl/servo_pkg.sv
// Shared sizing defaults and FSM state type for the servo ramp controller.
package servo_pkg;
  localparam int NCH      = 8;
  localparam int W        = 32;
  localparam int CHW      = $clog2(NCH);
  localparam int PERIOD   = 1_000_000;
  localparam int TICK_DIV = 1_000_000;
  localparam int DMIN     = 50_000;
  localparam int DMAX     = 100_000;
  localparam int RST_DUTY = 75_000;

  typedef enum logic {IDLE, SWEEP} state_t;
endpackage

// File: rtl/ramp_step.sv
// Next duty for one channel: move toward target by at most step (step 0 jumps).
module ramp_step import servo_pkg::*; #(
  parameter int W = servo_pkg::W
) (
  input  logic [W-1:0] cur,
  input  logic [W-1:0] tgt,
  input  logic [W-1:0] step,
  output logic [W-1:0] next_duty
);
  logic [W-1:0] up, dn;

  // Differences are only used on the side where they cannot underflow.
  assign up = tgt - cur;
  assign dn = cur - tgt;

  always_comb begin
    next_duty = cur;
    if (cur < tgt)
      next_duty = (step == '0 || up <= step) ? tgt : cur + step;
    else if (cur > tgt)
      next_duty = (step == '0 || dn <= step) ? tgt : cur - step;
  end
endmodule

// File: rtl/servo_ramp_ctrl.sv
// Per-channel PWM period/duty/enable owner; slews duty toward commanded targets
// one channel per cycle in a sweep that runs once every TICK_DIV cycles.
module servo_ramp_ctrl import servo_pkg::*; #(
  parameter int NCH      = servo_pkg::NCH,
  parameter int W        = servo_pkg::W,
  parameter int PERIOD   = servo_pkg::PERIOD,
  parameter int TICK_DIV = servo_pkg::TICK_DIV,
  parameter int DMIN     = servo_pkg::DMIN,
  parameter int DMAX     = servo_pkg::DMAX,
  parameter int RST_DUTY = servo_pkg::RST_DUTY,
  localparam int CHW     = $clog2(NCH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [CHW-1:0]    cmd_ch,
  input  logic [W-1:0]      cmd_target,
  input  logic [W-1:0]      cmd_step,
  input  logic              cmd_en,
  output logic [NCH*W-1:0]  period,
  output logic [NCH*W-1:0]  duty,
  output logic [NCH-1:0]    en,
  output logic [NCH-1:0]    busy,
  output logic              all_done
);
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [W-1:0] DMIN_W = W'(DMIN);
  localparam logic [W-1:0] DMAX_W = W'(DMAX);
  localparam logic [W-1:0] RST_W  = W'(RST_DUTY);
  localparam logic [W-1:0] PER_W  = W'(PERIOD);

  state_t                 state, state_n;
  logic [TW-1:0]          tick;
  logic [CHW-1:0]         idx;
  logic                   tick_tc, accept, last_ch;
  logic [W-1:0]           clamped, ramp_out;
  logic [NCH-1:0][W-1:0]  duty_q, tgt_q, step_q;
  logic [NCH-1:0][W-1:0]  duty_n, tgt_n, step_n;
  logic [NCH-1:0]         en_q, en_n, busy_q, busy_n;

  assign tick_tc   = (tick == TW'(TICK_DIV - 1));
  assign last_ch   = (idx == CHW'(NCH - 1));
  assign cmd_ready = (state == IDLE);
  assign accept    = cmd_valid & cmd_ready;
  assign clamped   = (cmd_target < DMIN_W) ? DMIN_W :
                     (cmd_target > DMAX_W) ? DMAX_W : cmd_target;

  ramp_step #(.W(W)) u_ramp (
    .cur       (duty_q[idx]),
    .tgt       (tgt_q[idx]),
    .step      (step_q[idx]),
    .next_duty (ramp_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (tick_tc) state_n = SWEEP;
      SWEEP:   if (last_ch) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Commands and sweep updates are mutually exclusive by state, so a channel
  // never sees both in the same cycle.
  always_comb begin
    duty_n = duty_q;
    tgt_n  = tgt_q;
    step_n = step_q;
    en_n   = en_q;
    if (state == SWEEP) begin
      if (en_q[idx]) duty_n[idx] = ramp_out;
    end else if (accept && int'(cmd_ch) < NCH) begin
      tgt_n[cmd_ch]  = clamped;
      step_n[cmd_ch] = cmd_step;
      en_n[cmd_ch]   = cmd_en;
    end
    for (int k = 0; k < NCH; k++)
      busy_n[k] = en_n[k] & (duty_n[k] != tgt_n[k]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick   <= '0;
      idx    <= '0;
      duty_q <= {NCH{RST_W}};
      tgt_q  <= {NCH{RST_W}};
      step_q <= '0;
      en_q   <= '0;
      busy_q <= '0;
    end else begin
      tick   <= tick_tc ? '0 : tick + TW'(1);
      idx    <= (state == SWEEP && !last_ch) ? idx + CHW'(1) : '0;
      duty_q <= duty_n;
      tgt_q  <= tgt_n;
      step_q <= step_n;
      en_q   <= en_n;
      busy_q <= busy_n;
    end
  end

  assign period   = {NCH{PER_W}};
  assign duty     = duty_q;
  assign en       = en_q;
  assign busy     = busy_q;
  assign all_done = ~|busy_q;
endmodule

// File: tb/tb_servo_ramp_ctrl.sv
// Self-checking bench: cycle-accurate reference model driven by the tick schedule,
// clamp vector table, directed ramp/handshake/reset sequences and random traffic.
module tb_servo_ramp_ctrl;
  localparam int NCH = 8;
  localparam int W   = 32;
  localparam int CHW = 3;
  localparam int TD  = 16;
  localparam longint DMIN = 50000, DMAX = 100000, RST = 75000, PER = 1000000;

  logic             clk = 0, rst_n = 0;
  logic             cmd_valid = 0, cmd_en = 0;
  logic [CHW-1:0]   cmd_ch = '0;
  logic [W-1:0]     cmd_target = '0, cmd_step = '0;
  logic             cmd_ready, all_done;
  logic [NCH*W-1:0] period, duty;
  logic [NCH-1:0]   en, busy;

  servo_ramp_ctrl #(.TICK_DIV(TD)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_ch(cmd_ch), .cmd_target(cmd_target), .cmd_step(cmd_step), .cmd_en(cmd_en),
    .period(period), .duty(duty), .en(en), .busy(busy), .all_done(all_done)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  longint mduty[NCH], mtgt[NCH], mstep[NCH];
  bit     men[NCH];
  int     ecount, nacc;

  typedef struct {
    int     ch;
    longint tgt;
    longint step;
    longint exp_duty;
  } vec_t;
  vec_t vecs[8];

  task automatic chk(input string name, input logic [NCH*W-1:0] act, input logic [NCH*W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Sweep happens in the NCH cycles right after each tick wrap (never before the first wrap).
  function automatic bit sweeping(input int e);
    return (e >= TD) && ((e % TD) < NCH);
  endfunction

  function automatic longint ramp(input longint c, input longint t, input longint s);
    longint d = t - c;
    if (s == 0)  return t;
    if (d > s)   return c + s;
    if (d < -s)  return c - s;
    return t;
  endfunction

  function automatic longint clampv(input longint v);
    return (v < DMIN) ? DMIN : (v > DMAX) ? DMAX : v;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NCH; k++) begin
      mduty[k] = RST; mtgt[k] = RST; mstep[k] = 0; men[k] = 0;
    end
    ecount = 0;
  endtask

  task automatic check_all();
    logic [NCH*W-1:0] ed, ep;
    logic [NCH-1:0]   ee, eb;
    for (int k = 0; k < NCH; k++) begin
      ed[k*W +: W] = mduty[k][W-1:0];
      ep[k*W +: W] = PER[W-1:0];
      ee[k] = men[k];
      eb[k] = men[k] && (mduty[k] != mtgt[k]);
    end
    chk("duty", duty, ed);
    chk("en", en, ee);
    chk("busy", busy, eb);
    chk("all_done", all_done, eb == '0);
    chk("period", period, ep);
  endtask

  // Called at a negedge: drive, check ready, clock once, update model, check at negedge.
  task automatic cyc(input bit v, input int ch, input longint tg, input longint st, input bit e,
                     output bit acc);
    bit sw;
    cmd_valid = v; cmd_ch = ch[CHW-1:0]; cmd_target = tg[W-1:0];
    cmd_step = st[W-1:0]; cmd_en = e;
    #1;
    sw = sweeping(ecount);
    chk("cmd_ready", cmd_ready, !sw);
    acc = v && !sw;
    @(posedge clk);
    if (sw) begin
      int k = ecount % TD;
      if (men[k]) mduty[k] = ramp(mduty[k], mtgt[k], mstep[k]);
    end else if (v) begin
      nacc++;
      if (ch < NCH) begin
        mtgt[ch] = clampv(tg); mstep[ch] = st; men[ch] = e;
      end
    end
    ecount++;
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(input int n);
    bit a;
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, a);
  endtask

  task automatic send_cmd(input int ch, input longint tg, input longint st, input bit e);
    bit acc = 0;
    int n = 0;
    while (!acc && n < 40) begin cyc(1, ch, tg, st, e, acc); n++; end
    cmd_valid = 0;
    checks++;
    if (!acc) begin errors++; $display("FAIL send_cmd: not accepted within 40 cycles"); end
  endtask

  task automatic to_after_sweep();
    int n = 0;
    idle(1);
    while (!(ecount >= TD + NCH && ecount % TD == NCH) && n < 40) begin idle(1); n++; end
    checks++;
    if (n >= 40) begin errors++; $display("FAIL to_after_sweep: no sweep end within 40 cycles"); end
  endtask

  task automatic do_reset();
    cmd_valid = 0;
    #2 rst_n = 0;
    #1;
    model_reset();
    check_all();
    chk("reset cmd_ready", cmd_ready, 1'b1);
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    bit a;
    int lows, acc0;
    longint exp3[4] = '{74000, 73000, 72500, 72500};

    vecs[0] = '{5, 200000, 0,     100000};
    vecs[1] = '{5, 10,     0,     50000};
    vecs[2] = '{3, 60000,  0,     60000};
    vecs[3] = '{0, 49999,  0,     50000};
    vecs[4] = '{7, 100001, 0,     100000};
    vecs[5] = '{6, 50000,  0,     50000};
    vecs[6] = '{1, 99999,  60000, 99999};
    vecs[7] = '{1, 50000,  20000, 79999};

    nacc = 0;
    @(negedge clk);
    do_reset();

    // Ramp up: 76000..80000 over five ticks, busy drops with the last step.
    send_cmd(2, 80000, 1000, 1);
    chk("t2 en2", en[2], 1'b1);
    for (int i = 1; i <= 5; i++) begin
      to_after_sweep();
      chk("t2 duty2", duty[2*W +: W], 32'(75000 + 1000 * i));
      chk("t2 busy2", busy[2], (i < 5));
    end
    to_after_sweep();
    chk("t2 hold", duty[2*W +: W], 32'd80000);

    // Ramp down with a final partial step.
    @(negedge clk);
    do_reset();
    send_cmd(2, 72500, 1000, 1);
    for (int i = 0; i < 4; i++) begin
      to_after_sweep();
      chk("t3 duty2", duty[2*W +: W], exp3[i][W-1:0]);
    end

    // Clamp table, jump or large-step commands.
    foreach (vecs[i]) begin
      send_cmd(vecs[i].ch, vecs[i].tgt, vecs[i].step, 1);
      to_after_sweep();
      chk("table duty", duty[vecs[i].ch*W +: W], vecs[i].exp_duty[W-1:0]);
    end

    // Held command during a sweep: ready low exactly NCH cycles, accepted once.
    @(negedge clk);
    do_reset();
    idle(TD);
    acc0 = nacc;
    lows = 0;
    cmd_valid = 1;
    #1;
    while (!cmd_ready && lows < 20) begin cyc(1, 4, 90000, 0, 1, a); lows++; end
    cyc(1, 4, 90000, 0, 1, a);
    cmd_valid = 0;
    chk("t5 ready_low_cycles", 256'(lows), 256'(NCH));
    idle(3);
    chk("t5 accept_count", 256'(nacc - acc0), 256'd1);
    to_after_sweep();
    chk("t5 duty4", duty[4*W +: W], 32'd90000);

    // Command on the terminal-count cycle is used by the sweep that starts next.
    while (ecount % TD != TD - 1) idle(1);
    send_cmd(6, 60000, 0, 1);
    idle(NCH);
    chk("tc duty6", duty[6*W +: W], 32'd60000);

    // Disable mid-ramp freezes duty, re-enable resumes, async reset mid-sweep.
    @(negedge clk);
    do_reset();
    send_cmd(1, 90000, 1000, 1);
    for (int i = 0; i < 3; i++) to_after_sweep();
    chk("t6 duty1", duty[1*W +: W], 32'd78000);
    send_cmd(1, 90000, 1000, 0);
    chk("t6 en1", en[1], 1'b0);
    chk("t6 busy1", busy[1], 1'b0);
    to_after_sweep();
    to_after_sweep();
    chk("t6 frozen", duty[1*W +: W], 32'd78000);
    send_cmd(1, 90000, 1000, 1);
    to_after_sweep();
    chk("t6 resume", duty[1*W +: W], 32'd79000);
    while (ecount % TD != 3) idle(1);
    do_reset();

    // Random traffic against the model.
    for (int i = 0; i < 800; i++) begin
      longint tg = $urandom_range(130000, 30000);
      longint st = ($urandom_range(3) == 0) ? 0 : $urandom_range(8000, 1);
      cyc($urandom_range(2) == 0, $urandom_range(NCH - 1), tg, st, $urandom_range(3) != 0, a);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
